// File: rtl/adder_share_arbiter.sv
// Round-robin front end sharing one pipelined adder core among NUM_REQ requesters.
// Requester IDs ride alongside the core; results land in a credit-gated response FIFO.
module adder_share_arbiter #(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 4,
    parameter int LAT     = 3,
    parameter int DEPTH   = 8,
    parameter int IDW     = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0]       req_cin,
    output logic                     core_v_in,
    output logic [WIDTH-1:0]         core_a,
    output logic [WIDTH-1:0]         core_b,
    output logic                     core_cin,
    input  logic [WIDTH-1:0]         core_sum,
    input  logic                     core_v_out,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic [IDW-1:0]           rsp_id,
    output logic                     err_vmismatch
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int WARM_W = $clog2(LAT + 1);

    typedef struct packed {
        logic           vld;
        logic [IDW-1:0] id;
    } trk_t;

    logic [IDX_W-1:0]  rr_q, rr_d;
    logic [IDX_W-1:0]  cand;
    logic [IDX_W-1:0]  grant_idx;
    logic              grant_vld;
    logic              credit_ok;
    logic [WARM_W-1:0] inflight;
    trk_t              trk_q [1:LAT];

    logic [WIDTH-1:0]  mem_sum_q [DEPTH];
    logic [IDW-1:0]    mem_id_q  [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WARM_W-1:0] warm_q, warm_d;
    logic              err_q, err_d;
    logic              push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Credits count buffered plus in-flight results; a pop in this cycle is not credited
    // until it shows up in cnt_q. Grants are also held off while reset is asserted.
    always_comb begin
        inflight = '0;
        for (int k = 1; k <= LAT; k++) begin
            inflight = inflight + WARM_W'(trk_q[k].vld);
        end
        credit_ok = rst_n && ((int'(cnt_q) + int'(inflight)) < DEPTH);
    end

    // NOTE: every signal written in a combinational block gets a default first; a path
    // that leaves one unassigned would infer a latch.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        if (credit_ok) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                cand = IDX_W'((int'(rr_q) + k) % NUM_REQ);
                if (!grant_vld && req_valid[cand]) begin
                    grant_vld = 1'b1;
                    grant_idx = cand;
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        core_a    = '0;
        core_b    = '0;
        core_cin  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_vld && (grant_idx == IDX_W'(k))) begin
                req_ready[k] = 1'b1;
                core_a       = req_a[k*WIDTH +: WIDTH];
                core_b       = req_b[k*WIDTH +: WIDTH];
                core_cin     = req_cin[k];
            end
        end
        core_v_in = |req_ready;
    end

    assign rsp_valid     = (cnt_q != '0);
    assign rsp_sum       = mem_sum_q[rd_ptr_q];
    assign rsp_id        = mem_id_q[rd_ptr_q];
    assign err_vmismatch = err_q;

    // The tracker's last stage is the only capture strobe; core_v_out is merely audited.
    always_comb begin
        push     = trk_q[LAT].vld;
        pop      = rsp_valid & rsp_ready;
        rr_d     = rr_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        warm_d   = warm_q;
        err_d    = err_q;
        if (grant_vld) begin
            rr_d = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
        end
        if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        if (push && !pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        // The core's valid pipeline is unreset, so it is trusted only once LAT edges
        // of idle issue have flushed it.
        if (warm_q != WARM_W'(LAT)) begin
            warm_d = warm_q + WARM_W'(1);
        end else if (core_v_out != trk_q[LAT].vld) begin
            err_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge value of every other register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            warm_q   <= '0;
            err_q    <= 1'b0;
            for (int k = 1; k <= LAT; k++) begin
                trk_q[k] <= '0;
            end
        end else begin
            rr_q     <= rr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            warm_q   <= warm_d;
            err_q    <= err_d;
            trk_q[1] <= {core_v_in, IDW'(grant_idx)};
            for (int k = 2; k <= LAT; k++) begin
                trk_q[k] <= trk_q[k-1];
            end
        end
    end

    // NOTE: FIFO storage is deliberately not reset; occupancy is tracked by cnt_q and
    // the head entry is only observed while rsp_valid is high.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_sum_q[wr_ptr_q] <= core_sum;
            mem_id_q[wr_ptr_q]  <= trk_q[LAT].id;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && (cnt_q == CNT_W'(DEPTH))));

    a_grant_legal: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(req_ready) && ((req_ready & ~req_valid) == '0));

endmodule
